shim_trig_data_unpacker: RTL and testbench

Consumer end of the trigger timestamp data FIFO. Pops the two-word records written by the trigger core on every trigger (low 32 bits of the 64-bit trigger timer first, then high 32 bits) and reassembles each into a 64-bit timestamp. Computes the interval to the previous trigger and presents both on a valid/ready stream toward the PS-side readout logic. Flags framing loss and non-monotonic timestamps.

---
 rtl/shim_trig_pkg.sv | 30 +++
 rtl/shim_trig_ts_delta.sv | 33 +++
 rtl/shim_trig_data_unpacker.sv | 175 +++++++++++++++++
 tb/tb_shim_trig_data_unpacker.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shim_trig_pkg.sv
// rtl/shim_trig_pkg.sv - shared types and constants for the trigger timestamp unpacker
//
// Holds the unpacker state encoding, the layout of a FIFO record (word count,
// word width, word order) and the timestamp width/saturation value.

package shim_trig_pkg;

  // Timestamp produced by the trigger core's 64-bit timer.
  localparam int TS_W = 64;

  // A record is two 32-bit FIFO words; the low half of the timer is written first.
  localparam int WORD_W    = 32;
  localparam int REC_WORDS = 2;
  localparam int WORD_LO   = 0;
  localparam int WORD_HI   = 1;

  // The timer saturates here instead of wrapping, so repeats of this value are legal.
  localparam logic [TS_W-1:0] TS_SAT = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    S_LO  = 2'd0,  // waiting for the low word of a record
    S_HI  = 2'd1,  // low word held, waiting for the high word
    S_OUT = 2'd2   // assembled record presented downstream
  } state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/shim_trig_ts_delta.sv
// rtl/shim_trig_ts_delta.sv - interval and ordering check between consecutive timestamps
//
// Purely combinational; the parent registers the results alongside the timestamp.
//
// Ports:
//   ts_new     - timestamp just assembled
//   ts_prev    - timestamp of the previous delivered record
//   have_prev  - ts_prev is meaningful (cleared by reset/flush)
//   delta      - ts_new - ts_prev, wrapping; 0 when there is no history
//   order_viol - ts_new does not advance past ts_prev

module shim_trig_ts_delta
  import shim_trig_pkg::*;
(
  input  logic [TS_W-1:0] ts_new,
  input  logic [TS_W-1:0] ts_prev,
  input  logic            have_prev,
  output logic [TS_W-1:0] delta,
  output logic            order_viol
);

  always_comb begin
    delta      = '0;
    order_viol = 1'b0;
    if (have_prev) begin
      delta = ts_new - ts_prev;
      // A saturated timer keeps returning TS_SAT, so an equal pair there is not an error.
      order_viol = (ts_new < ts_prev) ||
                   ((ts_new == ts_prev) && (ts_prev != TS_SAT));
    end
  end

endmodule

// File: rtl/shim_trig_data_unpacker.sv
// rtl/shim_trig_data_unpacker.sv - pops two-word trigger records and streams 64-bit timestamps
//
// Consumer end of the trigger timestamp FIFO (first-word-fall-through). Each
// record is {low word, high word}; the reassembled timestamp and its interval
// to the previous record are offered on a valid/ready stream.
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   data_word_rd_en  - FIFO pop (combinational)
//   data_word        - FIFO head word, valid while data_buf_empty is low
//   data_buf_empty   - FIFO empty
//   flush            - drop partial/pending record and timestamp history
//   ts_valid/ts_ready- output handshake
//   ts, ts_delta     - timestamp and interval to previous record
//   ts_count         - records accepted downstream, saturating
//   frame_err        - sticky: high word did not arrive within FRAME_TIMEOUT cycles
//   order_err        - sticky: timestamp did not increase

module shim_trig_data_unpacker
  import shim_trig_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              data_word_rd_en,
  input  logic [WORD_W-1:0] data_word,
  input  logic              data_buf_empty,
  input  logic              flush,
  output logic              ts_valid,
  input  logic              ts_ready,
  output logic [TS_W-1:0]   ts,
  output logic [TS_W-1:0]   ts_delta,
  output logic [31:0]       ts_count,
  output logic              frame_err,
  output logic              order_err
);

  localparam int TMO_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FRAME_TIMEOUT - 1);

  state_e state_q, state_d;

  logic [WORD_W-1:0] lo_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [TS_W-1:0]   prev_q;
  logic              have_prev_q;

  logic pop_lo, pop_hi, tmo_hit, accept;

  logic [REC_WORDS-1:0][WORD_W-1:0] new_rec;
  logic [TS_W-1:0]                  new_ts;
  logic [TS_W-1:0]                  new_delta;
  logic                             new_viol;

  always_comb begin
    new_rec          = '0;
    new_rec[WORD_LO] = lo_q;
    new_rec[WORD_HI] = data_word;
  end

  assign new_ts = new_rec;

  shim_trig_ts_delta u_ts_delta (
    .ts_new     (new_ts),
    .ts_prev    (prev_q),
    .have_prev  (have_prev_q),
    .delta      (new_delta),
    .order_viol (new_viol)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    data_word_rd_en = 1'b0;
    ts_valid        = 1'b0;
    pop_lo          = 1'b0;
    pop_hi          = 1'b0;
    tmo_hit         = 1'b0;
    accept          = 1'b0;

    case (state_q)
      S_LO: begin
        if (!data_buf_empty) begin
          data_word_rd_en = 1'b1;
          pop_lo          = 1'b1;
          state_d         = S_HI;
        end
      end
      S_HI: begin
        if (!data_buf_empty) begin
          data_word_rd_en = 1'b1;
          pop_hi          = 1'b1;
          state_d         = S_OUT;
        end else if (tmo_q == TMO_LAST) begin
          // Give up on this record; the next word is taken as a fresh low word.
          tmo_hit = 1'b1;
          state_d = S_LO;
        end
      end
      S_OUT: begin
        ts_valid = 1'b1;
        if (ts_ready) begin
          accept  = 1'b1;
          state_d = S_LO;
        end
      end
      default: state_d = S_LO;
    endcase

    // Reset and flush act in the current cycle: nothing is popped or accepted.
    if (reset || flush) begin
      data_word_rd_en = 1'b0;
      pop_lo          = 1'b0;
      pop_hi          = 1'b0;
      tmo_hit         = 1'b0;
      accept          = 1'b0;
      state_d         = S_LO;
    end
  end

  // tmo_q counts cycles elapsed since the low word was popped, so it is loaded
  // with 1 and the record is abandoned as it would reach FRAME_TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q        <= '0;
      tmo_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      ts          <= '0;
      ts_delta    <= '0;
      ts_count    <= '0;
      frame_err   <= 1'b0;
      order_err   <= 1'b0;
    end else begin
      if (pop_lo) begin
        lo_q  <= data_word;
        tmo_q <= TMO_ONE;
      end else if (state_q == S_HI) begin
        tmo_q <= tmo_q + TMO_ONE;
      end

      if (pop_hi) begin
        ts          <= new_ts;
        ts_delta    <= new_delta;
        prev_q      <= new_ts;
        have_prev_q <= 1'b1;
        if (new_viol) begin
          order_err <= 1'b1;
        end
      end

      if (tmo_hit) begin
        frame_err <= 1'b1;
      end

      if (accept) begin
        ts_count <= sat_inc32(ts_count);
      end

      if (flush) begin
        have_prev_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shim_trig_data_unpacker.sv
// tb/tb_shim_trig_data_unpacker.sv - self-checking bench for shim_trig_data_unpacker

module tb_shim_trig_data_unpacker;

  localparam int FT = 16;

  typedef struct {
    logic [63:0] ts;
    logic [63:0] delta;
    bit          viol;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_word_rd_en;
  logic [31:0] data_word;
  logic        data_buf_empty;
  logic        flush;
  logic        ts_valid;
  logic        ts_ready;
  logic [63:0] ts;
  logic [63:0] ts_delta;
  logic [31:0] ts_count;
  logic        frame_err;
  logic        order_err;

  always #5 clk = ~clk;

  shim_trig_data_unpacker #(.FRAME_TIMEOUT(FT)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_word_rd_en (data_word_rd_en),
    .data_word       (data_word),
    .data_buf_empty  (data_buf_empty),
    .flush           (flush),
    .ts_valid        (ts_valid),
    .ts_ready        (ts_ready),
    .ts              (ts),
    .ts_delta        (ts_delta),
    .ts_count        (ts_count),
    .frame_err       (frame_err),
    .order_err       (order_err)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] fifo[$];
  rec_t        exp_q[$];
  logic [63:0] m_prev;
  bit          m_have;
  bit          m_order;
  int          m_count;
  int          cyc;
  bit          last_pop;
  logic [63:0] last_ts;
  logic [63:0] last_delta;
  int          acc_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    data_buf_empty = (fifo.size() == 0);
    data_word      = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  // Reference: every pushed pair becomes one delivered record, in push order.
  task automatic push_rec(input logic [63:0] t);
    rec_t r;
    fifo.push_back(t[31:0]);
    fifo.push_back(t[63:32]);
    r.ts = t;
    if (m_have) begin
      r.delta = t - m_prev;
      r.viol  = (t < m_prev) || (t == m_prev && m_prev != 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      r.delta = 64'h0;
      r.viol  = 1'b0;
    end
    m_prev = t;
    m_have = 1'b1;
    exp_q.push_back(r);
    refresh();
  endtask

  task automatic step();
    rec_t e;
    bit   pop;
    @(negedge clk);
    pop = data_word_rd_en;
    if (ts_valid && ts_ready && !flush && !reset) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rec", ts_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rec_ts", ts, e.ts);
        chk("rec_delta", ts_delta, e.delta);
        m_order = m_order | e.viol;
        chk("rec_order_err", order_err, m_order);
        m_count++;
        last_ts    = ts;
        last_delta = ts_delta;
        acc_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    last_pop = pop;
    if (pop) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      else chk("pop_when_empty", pop, 0);
    end
    refresh();
  endtask

  task automatic drain();
    ts_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && fifo.size() == 0 && !ts_valid) break;
      step();
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush  = 1'b0;
    m_have = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_have  = 1'b0;
    m_order = 1'b0;
    m_count = 0;
    exp_q.delete();
  endtask

  initial begin
    int          c0;
    int          cnt0;
    logic [63:0] gen;
    logic [63:0] t;
    int          mode;

    reset = 1'b1; flush = 1'b0; ts_ready = 1'b0;
    cyc = 0; m_prev = '0; last_ts = '0; last_delta = '0;
    refresh();
    do_reset();

    chk("rst_valid", ts_valid, 0);
    chk("rst_ts", ts, 0);
    chk("rst_delta", ts_delta, 0);
    chk("rst_count", ts_count, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_order_err", order_err, 0);

    // Two back-to-back records: latency and throughput.
    ts_ready = 1'b1;
    acc_cyc.delete();
    c0 = cyc;
    push_rec(64'h0);
    push_rec(64'h1388);
    drain();
    chk("acc_n", acc_cyc.size(), 2);
    if (acc_cyc.size() >= 2) begin
      chk("latency", acc_cyc[0] - c0, 2);
      chk("throughput", acc_cyc[1] - acc_cyc[0], 3);
    end
    chk("last_delta_1388", last_delta, 64'h1388);
    chk("count_2", ts_count, 2);
    chk("no_frame_err", frame_err, 0);
    chk("no_order_err", order_err, 0);

    // Carry across the 32-bit word boundary.
    push_rec(64'hFFFF_FFFF);
    push_rec(64'h1_0000_0005);
    drain();
    chk("carry_ts", last_ts, 64'h1_0000_0005);
    chk("carry_delta", last_delta, 64'd6);

    // Decreasing timestamps.
    flush_pulse();
    push_rec(64'h100);
    push_rec(64'h80);
    drain();
    chk("dec_delta", last_delta, 64'hFFFF_FFFF_FFFF_FF80);
    chk("dec_order_err", order_err, 1);
    chk("count_6", ts_count, 6);

    // Reset in the middle of a record.
    fifo.push_back(32'hDEAD);
    refresh();
    step();
    chk("mid_pop_lo", last_pop, 1);
    fifo.push_back(32'h1234);
    refresh();
    reset = 1'b1;
    step();
    chk("rd_en_in_reset", last_pop, 0);
    step();
    reset = 1'b0;
    fifo.delete();
    refresh();
    m_have = 1'b0; m_order = 1'b0; m_count = 0; exp_q.delete();
    step();
    chk("mid_rst_valid", ts_valid, 0);
    chk("mid_rst_ts", ts, 0);
    chk("mid_rst_delta", ts_delta, 0);
    chk("mid_rst_count", ts_count, 0);
    chk("mid_rst_order", order_err, 0);

    // Saturated timer repeating is not an ordering error.
    push_rec(64'hFFFF_FFFF_FFFF_FFFF);
    push_rec(64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    chk("sat_order_err", order_err, 0);
    chk("sat_delta", last_delta, 0);

    // Backpressure with three records queued.
    flush_pulse();
    ts_ready = 1'b0;
    push_rec(64'h7_0000_1000);
    push_rec(64'h7_0000_2000);
    push_rec(64'h7_0000_3000);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_no_pop", last_pop, 0);
      chk("hold_valid", ts_valid, 1);
      chk("hold_ts", ts, 64'h7_0000_1000);
    end
    drain();
    chk("hold_last_ts", last_ts, 64'h7_0000_3000);
    chk("hold_count", ts_count, 5);

    // Flush while a record is held, with ts_ready high.
    ts_ready = 1'b0;
    push_rec(64'h7_0000_5000);
    step();
    step();
    chk("flush_pre_valid", ts_valid, 1);
    cnt0 = m_count;
    flush = 1'b1;
    ts_ready = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_front());
    m_have = 1'b0;
    chk("flush_valid_gone", ts_valid, 0);
    chk("flush_count", ts_count, cnt0);
    push_rec(64'h200);
    drain();
    chk("flush_new_ts", last_ts, 64'h200);
    chk("flush_new_delta", last_delta, 0);
    chk("flush_count_after", ts_count, cnt0 + 1);

    // Missing high word: frame timeout.
    fifo.push_back(32'h77);
    refresh();
    step();
    chk("tmo_pop_lo", last_pop, 1);
    c0 = cyc - 1;
    for (int k = 0; k < FT + 2; k++) begin
      chk("tmo_frame_err", frame_err, (cyc - c0) >= FT);
      chk("tmo_no_valid", ts_valid, 0);
      step();
    end
    push_rec(64'h300);
    drain();
    chk("tmo_next_ts", last_ts, 64'h300);
    chk("tmo_history_kept", last_delta, 64'h100);

    // Randomized traffic.
    gen = 64'h300;
    for (int i = 0; i < 600; i++) begin
      if (fifo.size() < 6 && $urandom_range(0, 2) == 0) begin
        mode = $urandom_range(0, 9);
        if (mode < 7)       t = gen + 64'($urandom_range(1, 5000));
        else if (mode == 7) t = {$urandom, $urandom};
        else if (mode == 8) t = gen;
        else                t = gen - 64'($urandom_range(1, 100));
        gen = t;
        push_rec(t);
      end
      ts_ready = ($urandom_range(0, 3) != 0);
      if (fifo.size() == 0 && exp_q.size() == 0 && $urandom_range(0, 29) == 0) flush_pulse();
      else step();
    end
    drain();
    chk("rand_count", ts_count, m_count);
    chk("rand_order_err", order_err, m_order);
    chk("rand_frame_err", frame_err, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
